// File: rtl/oam_dma.sv
// Sprite DMA: snoops the CPU write to REG_ADDR, stalls the CPU, then copies
// 256 bytes from page {data,8'h00} to the PPU OAM data port.
module oam_dma #(
  parameter logic [15:0] REG_ADDR  = 16'h4014,
  parameter logic [15:0] DEST_ADDR = 16'h2004,
  parameter int          COUNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [15:0] cpu_ea,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wreq,
  input  logic [7:0]  mem_din,
  output logic        rdy,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_dout,
  output logic        dma_rd,
  output logic        dma_wreq,
  output logic        busy
);

  // Handshake: the CPU is stalled whenever rdy=0 on a ce; the DMA strobes are
  // held for the whole state and the consumer qualifies them with its own ce.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t               state;
  logic [7:0]           page;
  logic [COUNT_W-1:0]   index;
  logic                 parity;

  logic [15:0] cur_rd_addr;
  logic [15:0] nxt_rd_addr;
  logic        trigger;

  assign cur_rd_addr = {page, 8'h00} + 16'(index);
  assign nxt_rd_addr = {page, 8'h00} + 16'(index) + 16'd1;
  assign trigger     = cpu_wreq && (cpu_ea == REG_ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rdy        <= 1'b1;
      busy       <= 1'b0;
      dma_active <= 1'b0;
      dma_addr   <= '0;
      dma_dout   <= '0;
      dma_rd     <= 1'b0;
      dma_wreq   <= 1'b0;
      page       <= '0;
      index      <= '0;
      parity     <= 1'b0;
    end else if (ce) begin
      parity <= ~parity;
      unique case (state)
        IDLE: begin
          if (trigger) begin
            page  <= cpu_dout;
            index <= '0;
            rdy   <= 1'b0;
            busy  <= 1'b1;
            state <= HALT;
          end
        end
        HALT: begin
          // Align when this ce's toggled parity lands on a put cycle,
          // i.e. the trigger itself arrived on an odd cycle.
          if (!parity) begin
            state <= ALIGN;
          end else begin
            state      <= READ;
            dma_addr   <= cur_rd_addr;
            dma_rd     <= 1'b1;
            dma_active <= 1'b1;
          end
        end
        ALIGN: begin
          state      <= READ;
          dma_addr   <= cur_rd_addr;
          dma_rd     <= 1'b1;
          dma_active <= 1'b1;
        end
        READ: begin
          dma_dout <= mem_din;
          dma_addr <= DEST_ADDR;
          dma_rd   <= 1'b0;
          dma_wreq <= 1'b1;
          state    <= WRITE;
        end
        WRITE: begin
          dma_wreq <= 1'b0;
          if (index == '1) begin
            // Completion shares this ce: release the bus and the CPU together.
            dma_active <= 1'b0;
            rdy        <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            index    <= index + 1'b1;
            dma_addr <= nxt_rd_addr;
            dma_rd   <= 1'b1;
            state    <= READ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: SRAM model, scoreboard of expected OAM bytes, stall and
// address-sequence checks across parity, retrigger, reset and ce spacing.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic [15:0] cpu_ea;
  logic [7:0]  cpu_dout;
  logic        cpu_wreq;
  logic [7:0]  mem_din;
  logic        rdy;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic [7:0]  dma_dout;
  logic        dma_rd;
  logic        dma_wreq;
  logic        busy;

  oam_dma dut (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .cpu_ea     (cpu_ea),
    .cpu_dout   (cpu_dout),
    .cpu_wreq   (cpu_wreq),
    .mem_din    (mem_din),
    .rdy        (rdy),
    .dma_active (dma_active),
    .dma_addr   (dma_addr),
    .dma_dout   (dma_dout),
    .dma_rd     (dma_rd),
    .dma_wreq   (dma_wreq),
    .busy       (busy)
  );

  // clock / reset / memory model
  always #5 clk = ~clk;

  logic [7:0] sram [65536];
  always @(posedge clk) mem_din <= sram[dma_addr];

  // scoreboard state
  logic [7:0] exp_q[$];
  int         total = 0;
  int         bad   = 0;
  int         gap   = 3;
  logic [7:0] exp_page = 8'h00;
  int         rd_idx = 0;
  int         stall_cnt = 0;
  logic       last_rdy = 1'b1;
  logic       parity_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One ce pulse; outputs are sampled while ce is high, before the active edge.
  task automatic ce_cycle();
    repeat (gap - 1) @(negedge clk);
    ce = 1'b1;
    #1;
    if (dma_rd && dma_wreq) check("strobe_excl", 1, 0);
    if (dma_rd) begin
      check("rd_addr", dma_addr, {exp_page, rd_idx[7:0]});
      check("rd_active", dma_active, 1);
      rd_idx++;
    end
    if (dma_wreq) begin
      check("wr_addr", dma_addr, 16'h2004);
      check("wr_active", dma_active, 1);
      if (exp_q.size() == 0) check("wr_extra", 1, 0);
      else check("wr_data", dma_dout, exp_q.pop_front());
    end
    if (!rdy) stall_cnt++;
    last_rdy = rdy;
    @(negedge clk);
    ce = 1'b0;
    parity_m = ~parity_m;
  endtask

  task automatic run_dma(input logic [7:0] pg, input logic par, input int retrig_at,
                         input int abort_at, input int exp_stall);
    int  n;
    bit  retrig_done;
    while (parity_m != par) ce_cycle();
    exp_page  = pg;
    rd_idx    = 0;
    stall_cnt = 0;
    for (int i = 0; i < 256; i++) exp_q.push_back(sram[{pg, i[7:0]}]);
    cpu_ea = 16'h4014; cpu_dout = pg; cpu_wreq = 1'b1;
    ce_cycle();
    cpu_wreq = 1'b0; cpu_ea = 16'h0000;
    n = 0;
    retrig_done = 1'b0;
    do begin
      if (rd_idx == abort_at) begin
        reset = 1'b1;
        #1;
        check("abort_rdy", rdy, 1);
        check("abort_busy", busy, 0);
        check("abort_active", dma_active, 0);
        check("abort_rd", dma_rd, 0);
        check("abort_wreq", dma_wreq, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        parity_m = 1'b0;
        return;
      end
      if (rd_idx == retrig_at && !retrig_done) begin
        cpu_ea = 16'h4014; cpu_dout = 8'h07; cpu_wreq = 1'b1;
        retrig_done = 1'b1;
      end
      ce_cycle();
      cpu_wreq = 1'b0; cpu_ea = 16'h0000;
      n++;
    end while (!last_rdy && n < 600);
    if (n >= 600) check("timeout", n, 0);
    check("stall", stall_cnt, exp_stall);
    check("rd_count", rd_idx, 256);
    check("queue_empty", exp_q.size(), 0);
    check("done_busy", busy, 0);
    check("done_active", dma_active, 0);
    exp_q.delete();
  endtask

  task automatic idle_checks(input string tag);
    repeat (4) begin
      ce_cycle();
      check({tag, "_rdy"}, last_rdy, 1);
      check({tag, "_active"}, dma_active, 0);
      check({tag, "_busy"}, busy, 0);
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) sram[a] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 256; i++) sram[16'h0200 + i] = 8'(i);
    reset = 1'b1; ce = 1'b0; cpu_ea = '0; cpu_dout = '0; cpu_wreq = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rdy", rdy, 1);
    check("rst_busy", busy, 0);
    check("rst_active", dma_active, 0);
    check("rst_addr", dma_addr, 0);
    check("rst_dout", dma_dout, 0);
    check("rst_rd", dma_rd, 0);
    check("rst_wreq", dma_wreq, 0);
    reset = 1'b0;
    @(negedge clk);

    run_dma(8'h02, 1'b0, -1, -1, 513);   // even parity
    run_dma(8'h02, 1'b1, -1, -1, 514);   // odd parity, ALIGN
    run_dma(8'h02, 1'b0, 8'h40, -1, 513); // retrigger ignored
    run_dma(8'h02, 1'b0, -1, 8'h80, 0);   // reset mid-transfer
    run_dma(8'h13, 1'b1, -1, -1, 514);    // full transfer after reset
    run_dma(8'h40, 1'b0, -1, -1, 513);
    gap = 20;
    run_dma(8'h3A, 1'b0, -1, -1, 513);
    gap = 3;

    cpu_ea = 16'h4015; cpu_dout = 8'h02; cpu_wreq = 1'b1;
    ce_cycle();
    cpu_wreq = 1'b0;
    idle_checks("w4015");
    cpu_ea = 16'h2004; cpu_dout = 8'h02; cpu_wreq = 1'b1;
    ce_cycle();
    cpu_wreq = 1'b0;
    idle_checks("w2004");
    cpu_ea = 16'h4014; cpu_dout = 8'h02; cpu_wreq = 1'b1;
    repeat (2) @(negedge clk);
    cpu_wreq = 1'b0; cpu_ea = 16'h0000;
    idle_checks("no_ce");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
